// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle data-memory responder with byte-lane writes
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [3:0]  ByteEn,
  output logic [31:0] ReadData,
  output logic        Ack,
  output logic        Err,
  output logic        Busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  // Storage is never reset; it starts at zero and only writes change it.
  logic [31:0] mem [DEPTH] = '{default: '0};

  logic                  access;
  logic                  addr_err;
  logic [ADDR_WIDTH-1:0] widx;

  assign widx     = addr_q[ADDR_WIDTH+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_WIDTH+2] != '0);
  assign access   = (state_q == S_WAIT) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          we_d    = MemWrite;
          addr_d  = Address;
          wdata_d = WriteData;
          be_d    = ByteEn;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          ack_d   = 1'b1;
          err_d   = addr_err;
          // Writes leave ReadData alone; reads and rejects refresh it.
          if (addr_err) begin
            rdata_d = '0;
          end else if (!we_q) begin
            rdata_d = mem[widx];
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Commit happens on the WAIT->RESP edge; a reset on that edge aborts it.
  always_ff @(posedge Clk) begin
    if (!Reset && access && we_q && !addr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem[widx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign ReadData = rdata_q;
  assign Ack      = ack_q;
  assign Err      = err_q;
  assign Busy     = busy_q;

endmodule
